neural_argmax_seven: RTL and testbench

Parametrised, sequential successor to the combinational neural-output-to-seven-segment decoder. Accepts NUM_CLASSES signed class scores streamed one per clock over a valid/ready handshake and tracks the running arg-max. At frame end it applies a detection threshold and registers the winning class index and its seven-segment pattern. It sits between the network's output-layer serialiser and the board display driver.

---
 rtl/neural_argmax_seven.sv | 211 +++++++++++++++++++++
 tb/tb_neural_argmax_seven.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/neural_argmax_seven.sv
// neural_argmax_seven
// Streams NUM_CLASSES signed class scores (one per accepted transfer), tracks
// the running arg-max, then spends one DECIDE cycle applying the detection
// threshold and registering the winning digit and its seven-segment pattern.
// Optional build macro: NEURAL_MARGIN_EN adds second-best tracking and a
// best-minus-second-best gap test against MARGIN.
module neural_argmax_seven #(
  parameter int                        NUM_CLASSES = 10,
  parameter int                        DATA_W      = 16,
  parameter logic signed [DATA_W-1:0]  THRESH      = 16'sh0400,
  parameter logic signed [DATA_W-1:0]  MARGIN      = 16'sh0100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              score_valid,
  input  logic [DATA_W-1:0] score_data,
  output logic              score_ready,
  output logic              result_valid,
  output logic [3:0]        digit,
  output logic              no_match,
  output logic [7:0]        seven_seg
);

  // Class counter is sized for NUM_CLASSES; a two-class build still needs one bit.
  localparam int CNT_W = (NUM_CLASSES > 2) ? $clog2(NUM_CLASSES) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_CLASSES - 1);

  // Out-of-range configurations are rejected at elaboration time; a negative
  // MARGIN would make the gap test meaningless.
  if ((NUM_CLASSES < 2) || (NUM_CLASSES > 16) || (MARGIN < 0)) begin : g_param_check
    $error("neural_argmax_seven: NUM_CLASSES must be 2..16 and MARGIN non-negative");
  end

  typedef enum logic [0:0] {
    ST_ACCUM  = 1'b0,
    ST_DECIDE = 1'b1
  } state_t;

  // Seven-segment pattern for a hex digit, bit order {dp,g,f,e,d,c,b,a}.
  function automatic logic [7:0] seg_pattern(input logic [3:0] idx);
    logic [7:0] pat;
    case (idx)
      4'h0:    pat = 8'h3F;
      4'h1:    pat = 8'h06;
      4'h2:    pat = 8'h5B;
      4'h3:    pat = 8'h4F;
      4'h4:    pat = 8'h66;
      4'h5:    pat = 8'h6D;
      4'h6:    pat = 8'h7D;
      4'h7:    pat = 8'h07;
      4'h8:    pat = 8'h7F;
      4'h9:    pat = 8'h6F;
      4'hA:    pat = 8'h77;
      4'hB:    pat = 8'h7C;
      4'hC:    pat = 8'h39;
      4'hD:    pat = 8'h5E;
      4'hE:    pat = 8'h79;
      default: pat = 8'h71;
    endcase
    return pat;
  endfunction

`ifdef NEURAL_MARGIN_EN
  localparam logic signed [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  // Detection needs the winner above THRESH and clear of the runner-up by at
  // least MARGIN. The gap is formed one bit wider so a large positive best
  // against a large negative second cannot wrap.
  function automatic logic is_detect(input logic signed [DATA_W-1:0] best,
                                     input logic signed [DATA_W-1:0] second);
    logic signed [DATA_W:0] gap;
    logic signed [DATA_W:0] margin_x;
    gap      = {best[DATA_W-1], best} - {second[DATA_W-1], second};
    margin_x = {MARGIN[DATA_W-1], MARGIN};
    return (best > THRESH) && (gap >= margin_x);
  endfunction
`else
  // Detection depends on the winning score alone.
  function automatic logic is_detect(input logic signed [DATA_W-1:0] best);
    return best > THRESH;
  endfunction
`endif

  logic signed [DATA_W-1:0] score_s;
  assign score_s = score_data;

  state_t                   state_q,        state_d;
  logic [CNT_W-1:0]         cnt_q,          cnt_d;
  logic signed [DATA_W-1:0] best_val_q,     best_val_d;
  logic [3:0]               best_idx_q,     best_idx_d;
`ifdef NEURAL_MARGIN_EN
  logic signed [DATA_W-1:0] second_val_q,   second_val_d;
`endif
  logic                     result_valid_q, result_valid_d;
  logic [3:0]               digit_q,        digit_d;
  logic                     no_match_q,     no_match_d;
  logic [7:0]               seven_seg_q,    seven_seg_d;
  logic                     detect;

  // Decision for the frame currently held in the best/second registers.
`ifdef NEURAL_MARGIN_EN
  assign detect = is_detect(best_val_q, second_val_q);
`else
  assign detect = is_detect(best_val_q);
`endif

  // Next-state logic: accumulate scores in ACCUM, publish the result in DECIDE.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    best_val_d     = best_val_q;
    best_idx_d     = best_idx_q;
`ifdef NEURAL_MARGIN_EN
    second_val_d   = second_val_q;
`endif
    result_valid_d = 1'b0;
    digit_d        = digit_q;
    no_match_d     = no_match_q;
    seven_seg_d    = seven_seg_q;

    case (state_q)
      ST_ACCUM: begin
        if (clear) begin
          // Abort drops the partial frame; any same-cycle score is ignored.
          cnt_d = '0;
        end else if (score_valid) begin
          if (cnt_q == '0) begin
            best_val_d   = score_s;
            best_idx_d   = 4'h0;
`ifdef NEURAL_MARGIN_EN
            second_val_d = MOST_NEG;
`endif
          end else if (score_s > best_val_q) begin
            // Strict compare: on a tie the earlier (lower) index stays best.
`ifdef NEURAL_MARGIN_EN
            second_val_d = best_val_q;
`endif
            best_val_d   = score_s;
            best_idx_d   = 4'(cnt_q);
          end
`ifdef NEURAL_MARGIN_EN
          else if (score_s > second_val_q) begin
            second_val_d = score_s;
          end
`endif
          if (cnt_q == LAST_IDX) begin
            cnt_d   = '0;
            state_d = ST_DECIDE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      ST_DECIDE: begin
        // clear is deliberately not looked at here: the decision always completes.
        result_valid_d = 1'b1;
        state_d        = ST_ACCUM;
        if (detect) begin
          digit_d     = best_idx_q;
          no_match_d  = 1'b0;
          seven_seg_d = seg_pattern(best_idx_q);
        end else begin
          no_match_d  = 1'b1;
          seven_seg_d = 8'h00;
        end
      end

      default: begin
        state_d = ST_ACCUM;
      end
    endcase
  end

  // Control and display registers; rst restores the idle, blank display.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_ACCUM;
      cnt_q          <= '0;
      result_valid_q <= 1'b0;
      digit_q        <= 4'h0;
      no_match_q     <= 1'b1;
      seven_seg_q    <= 8'h00;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      result_valid_q <= result_valid_d;
      digit_q        <= digit_d;
      no_match_q     <= no_match_d;
      seven_seg_q    <= seven_seg_d;
    end
  end

  // Score datapath registers; always reloaded by the first score of a frame,
  // so they carry no reset.
  always_ff @(posedge clk) begin
    best_val_q   <= best_val_d;
    best_idx_q   <= best_idx_d;
`ifdef NEURAL_MARGIN_EN
    second_val_q <= second_val_d;
`endif
  end

  assign score_ready  = (state_q == ST_ACCUM);
  assign result_valid = result_valid_q;
  assign digit        = digit_q;
  assign no_match     = no_match_q;
  assign seven_seg    = seven_seg_q;

endmodule

// File: tb/tb_neural_argmax_seven.sv
// Directed testbench for neural_argmax_seven: a default 10-class instance and
// a 16-class instance share clock and reset. Inputs change on the falling
// edge; outputs are sampled on the falling edge.
module tb_neural_argmax_seven;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear1 = 1'b0, clear2 = 1'b0;
  logic        v1 = 1'b0, v2 = 1'b0;
  logic [15:0] d1 = 16'h0, d2 = 16'h0;
  logic        rdy1, rdy2, rv1, rv2, nm1, nm2;
  logic [3:0]  dig1, dig2;
  logic [7:0]  seg1, seg2;

  int errors = 0;
  int checks = 0;
  logic [15:0] fr [16];
  int rl, pc;

  always #5 clk = ~clk;

  neural_argmax_seven u_dut (
    .clk(clk), .rst(rst), .clear(clear1), .score_valid(v1), .score_data(d1),
    .score_ready(rdy1), .result_valid(rv1), .digit(dig1), .no_match(nm1),
    .seven_seg(seg1)
  );

  neural_argmax_seven #(.NUM_CLASSES(16)) u_dut16 (
    .clk(clk), .rst(rst), .clear(clear2), .score_valid(v2), .score_data(d2),
    .score_ready(rdy2), .result_valid(rv2), .digit(dig2), .no_match(nm2),
    .seven_seg(seg2)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill(input logic [15:0] val);
    for (int k = 0; k < 16; k++) fr[k] = val;
  endtask

  task automatic drive(input bit sel, input logic v, input logic [15:0] d);
    if (sel) begin v2 = v; d2 = d; end
    else     begin v1 = v; d1 = d; end
  endtask

  // Pushes n scores (frame content repeats every NUM_CLASSES). Returns with
  // valid dropped at the falling edge right after the last transfer.
  task automatic push(input bit sel, input int n, input bit bub,
                      output int rdy_low, output int pulses);
    int i, guard, ncls;
    ncls = sel ? 16 : 10;
    i = 0; guard = 0; rdy_low = 0; pulses = 0;
    while (i < n && guard < 400) begin
      @(negedge clk);
      guard++;
      if (sel ? rv2 : rv1) pulses++;
      if (bub && i < ncls && $urandom_range(0, 2) == 0) begin
        drive(sel, 1'b0, 16'h7FFF);
      end else begin
        drive(sel, 1'b1, fr[i % ncls]);
        if (sel ? rdy2 : rdy1) i++;
        else rdy_low++;
      end
    end
    if (i < n) begin
      checks++;
      errors++;
      $error("FAIL push_timeout: observed %0d transfers expected %0d", i, n);
    end
    @(negedge clk);
    drive(sel, 1'b0, 16'h7FFF);
  endtask

  // Checks the DECIDE cycle, the one-cycle result pulse and the published values.
  task automatic result(input string tag, input bit sel, input logic exp_nm,
                        input logic [3:0] exp_dig, input logic [7:0] exp_seg);
    chk({tag, "_decide_rdy"}, 16'(sel ? rdy2 : rdy1), 16'd0);
    chk({tag, "_decide_rv"},  16'(sel ? rv2 : rv1), 16'd0);
    @(negedge clk);
    chk({tag, "_rv"},    16'(sel ? rv2 : rv1), 16'd1);
    chk({tag, "_nm"},    16'(sel ? nm2 : nm1), 16'(exp_nm));
    chk({tag, "_digit"}, 16'(sel ? dig2 : dig1), 16'(exp_dig));
    chk({tag, "_seg"},   16'(sel ? seg2 : seg1), 16'(exp_seg));
    @(negedge clk);
    chk({tag, "_rv_off"}, 16'(sel ? rv2 : rv1), 16'd0);
    chk({tag, "_hold"},   16'(sel ? dig2 : dig1), 16'(exp_dig));
  endtask

  initial begin
    // Reset held for two rising edges.
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_seg",   16'(seg1), 16'h00);
    chk("rst_nm",    16'(nm1),  16'd1);
    chk("rst_digit", 16'(dig1), 16'd0);
    chk("rst_rdy",   16'(rdy1), 16'd1);
    chk("rst_rv",    16'(rv1),  16'd0);
    chk("rst_rdy16", 16'(rdy2), 16'd1);

    // Single peak at class 3.
    fill(16'h0000); fr[3] = 16'h0800;
    push(1'b0, 10, 1'b0, rl, pc);
    result("peak", 1'b0, 1'b0, 4'h3, 8'h4F);

    // All scores equal to THRESH: not strictly greater, so no detection.
    fill(16'h0400);
    push(1'b0, 10, 1'b0, rl, pc);
    result("thresh", 1'b0, 1'b1, 4'h3, 8'h00);

    // Tie between classes 2 and 7 keeps the lower index.
    fill(16'h0000); fr[2] = 16'h0900; fr[7] = 16'h0900;
    push(1'b0, 10, 1'b0, rl, pc);
    result("tie", 1'b0, 1'b0, 4'h2, 8'h5B);

    // Negative scores with bubbles, then a second identical frame back-to-back.
    fill(16'hF000); fr[9] = 16'h0500;
    push(1'b0, 20, 1'b1, rl, pc);
    chk("b2b_rdy_low", 16'(rl), 16'd1);
    chk("b2b_pulses",  16'(pc), 16'd1);
    result("neg", 1'b0, 1'b0, 4'h9, 8'h6F);

    // Abort after 5 scores; same-cycle score is ignored, display kept.
    fill(16'h0000); fr[4] = 16'h0800;
    push(1'b0, 5, 1'b0, rl, pc);
    clear1 = 1'b1; drive(1'b0, 1'b1, 16'h7FFF);
    @(negedge clk);
    clear1 = 1'b0; drive(1'b0, 1'b0, 16'h0000);
    chk("clr_rdy",   16'(rdy1), 16'd1);
    chk("clr_digit", 16'(dig1), 16'd9);
    fill(16'h0000); fr[0] = 16'h1000;
    push(1'b0, 10, 1'b0, rl, pc);
    result("clear", 1'b0, 1'b0, 4'h0, 8'h3F);

    // Reset during DECIDE: no pulse, reset values next cycle.
    fill(16'h0000); fr[3] = 16'h0800;
    push(1'b0, 10, 1'b0, rl, pc);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstd_rv",    16'(rv1),  16'd0);
    chk("rstd_digit", 16'(dig1), 16'd0);
    chk("rstd_nm",    16'(nm1),  16'd1);
    chk("rstd_seg",   16'(seg1), 16'h00);
    chk("rstd_rdy",   16'(rdy1), 16'd1);
    @(negedge clk);
    chk("rstd_rv2",   16'(rv1),  16'd0);

    // Close top two scores: margin test decides only when compiled in.
    fill(16'h0000); fr[4] = 16'h0900; fr[5] = 16'h0880;
    push(1'b0, 10, 1'b0, rl, pc);
`ifdef NEURAL_MARGIN_EN
    result("margin_close", 1'b0, 1'b1, 4'h0, 8'h00);
`else
    result("margin_close", 1'b0, 1'b0, 4'h4, 8'h66);
`endif
    fr[5] = 16'h0700;
    push(1'b0, 10, 1'b0, rl, pc);
    result("margin_wide", 1'b0, 1'b0, 4'h4, 8'h66);

    // 16-class instance: class 14 wins.
    fill(16'h0000); fr[14] = 16'h2000;
    push(1'b1, 16, 1'b0, rl, pc);
    result("n16", 1'b1, 1'b0, 4'hE, 8'h79);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
